pipe_exe_mem: RTL and testbench
===============================

PIPE_EXE_MEM -- requirements
Module: pipe_exe_mem

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: flush  in  1  synchronous pipeline kill.
REQ-004 SHALL have: in_valid  in  1  execute-stage beat present.
REQ-005 SHALL have: in_ready  out  1  block accepts a beat this cycle.
REQ-006 SHALL have: alu_result_in, write_data_in  in  32 each  ALU result and store data.
REQ-007 SHALL have: wa3_in  in  4  destination register; reg_write_in, mem_write_in, mem_to_reg_in  in  1 each.
REQ-008 SHALL have: cond_in  in  4  ARM condition field; flags_in  in  4  {N,Z,C,V}.
REQ-009 SHALL have: out_valid  out  1; out_ready  in  1  memory stage takes the beat.
REQ-010 SHALL have: alu_result_out, write_data_out (32), wa3_out (4), reg_write_out, mem_write_out, mem_to_reg_out (1 each).
REQ-011 SHALL have: occupancy  out  2  number of held beats, 0..2.

Function
REQ-012 SHALL hold two entries: main (drives outputs) and skid; each has a valid bit.
REQ-013 SHALL drive in_ready = !skid_valid, registered, with no combinational path from out_ready.
REQ-014 SHALL accept a beat when in_valid && in_ready, and retire it when out_valid && out_ready.
REQ-015 SHALL drive out_valid = main_valid; latency from accept to out_valid is 1 cycle when main is empty or retiring.
REQ-016 Main empty, accept: beat loads into main at the next edge.
REQ-017 Main full, retire, skid empty, accept: main reloads from the input and out_valid stays 1 with no bubble.
REQ-018 Main full, no retire, accept: beat loads into skid and in_ready falls at the next edge.
REQ-019 Skid full, retire: main loads from skid, skid clears, and in_ready rises at the next edge.
REQ-020 Main full, retire, no accept, skid empty: main_valid clears.
REQ-021 SHALL preserve beat order under all stall patterns; no beat is lost or duplicated.
REQ-022 SHALL force reg_write_out, mem_write_out and mem_to_reg_out to 0 whenever out_valid=0.
REQ-023 flush SHALL clear both valid bits at the next edge and discard any beat offered in the same cycle; flush overrides accept and retire.
REQ-024 occupancy SHALL equal main_valid + skid_valid.

Reset
REQ-025 On rst: all valid bits 0; every output 0 except in_ready, which is 1; occupancy 0.
REQ-026 rst asserted mid-transfer SHALL drop all held beats immediately; the first accept after release behaves as REQ-016.

Configuration
REQ-027 Macro PIPE_EXE_MEM_COND_EN, when defined: on accept, cond_in SHALL be evaluated against flags_in.
REQ-028 Condition codes: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL and 1111 always true.
REQ-029 With the macro, a failed condition SHALL store reg_write=0 and mem_write=0; the beat still occupies an entry so ordering is kept.
REQ-030 Without the macro, cond_in and flags_in SHALL be ignored, the ports SHALL remain, and the control bits pass unmodified.

Verification
REQ-031 Reset, then in_valid=1 with alu_result_in=0x0000_0010 and out_ready=1 -> out_valid=1 one cycle later, alu_result_out=0x10, occupancy=1.
REQ-032 out_ready=0, stream beats A=1, B=2, C=3 -> A held in main, B in skid, in_ready=0 and C not accepted, occupancy=2; then out_ready=1 -> outputs A, B, C in order with no duplicates.
REQ-033 Continuous in_valid=1 and out_ready=1 for 8 beats, values 0..7 -> out_valid stays 1 for 8 consecutive cycles and values 0..7 appear in order.
REQ-034 Both entries full, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the flushed beat never appears.
REQ-035 With PIPE_EXE_MEM_COND_EN: cond_in=0000, flags_in=0000 (Z=0), reg_write_in=1 -> reg_write_out=0 and out_valid=1; flags_in=0100 -> reg_write_out=1.
REQ-036 Assert rst while occupancy=2 -> all outputs 0 and in_ready=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_exe_mem.sv
// ---------------------------------------------------------------------------
// pipe_exe_mem
// Execute-to-memory pipeline register with a two-entry skid buffer.
//
// The "main" entry drives the memory-stage outputs. The "skid" entry catches
// a beat that was accepted while main was stalled. in_ready comes straight
// from a flop (!skid_valid), so there is no combinational path from
// out_ready back to in_ready.
//
// Optional feature, selected by the macro PIPE_EXE_MEM_COND_EN:
//   When defined, each accepted beat has its ARM condition (cond_in) checked
//   against flags_in. A failed condition stores reg_write=0 and mem_write=0.
//   The beat still takes an entry, so ordering is unchanged.
//   When undefined, cond_in and flags_in are ignored.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   flush           synchronous kill of both entries and any offered beat
//   in_valid/ready  execute-side handshake
//   alu_result_in, write_data_in, wa3_in, reg_write_in, mem_write_in,
//   mem_to_reg_in   execute-stage beat contents
//   cond_in, flags_in  condition field and {N,Z,C,V}
//   out_valid/ready memory-side handshake
//   *_out           beat held in main; control bits forced to 0 when idle
//   occupancy       number of held beats (0..2)
// ---------------------------------------------------------------------------
module pipe_exe_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [3:0]  wa3_in,
    input  logic        reg_write_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic [3:0]  cond_in,
    input  logic [3:0]  flags_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_result_out,
    output logic [31:0] write_data_out,
    output logic [3:0]  wa3_out,
    output logic        reg_write_out,
    output logic        mem_write_out,
    output logic        mem_to_reg_out,
    output logic [1:0]  occupancy
);

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [3:0]  wa3;
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
    } beat_t;

    beat_t main_q;
    beat_t skid_q;
    beat_t in_beat;
    logic  main_valid;
    logic  skid_valid;
    logic  accept;
    logic  retire;
    logic  cond_ok;

`ifdef PIPE_EXE_MEM_COND_EN
    // ARM condition evaluation; flags are packed {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond,
                                       input logic [3:0] flags);
        logic n, z, c, v;
        logic result;
        {n, z, c, v} = flags;
        case (cond)
            4'b0000: result = z;
            4'b0001: result = !z;
            4'b0010: result = c;
            4'b0011: result = !c;
            4'b0100: result = n;
            4'b0101: result = !n;
            4'b0110: result = v;
            4'b0111: result = !v;
            4'b1000: result = c && !z;
            4'b1001: result = !c || z;
            4'b1010: result = (n == v);
            4'b1011: result = (n != v);
            4'b1100: result = !z && (n == v);
            4'b1101: result = z || (n != v);
            default: result = 1'b1;
        endcase
        return result;
    endfunction

    assign cond_ok = cond_pass(cond_in, flags_in);
`else
    // Condition inputs are kept on the port list but have no effect.
    logic unused_cond;
    assign unused_cond = ^{cond_in, flags_in};
    assign cond_ok     = 1'b1;
`endif

    // A failed condition squashes the architectural side effects but keeps
    // the beat itself, so downstream ordering is unaffected.
    always_comb begin
        in_beat            = '0;
        in_beat.alu_result = alu_result_in;
        in_beat.write_data = write_data_in;
        in_beat.wa3        = wa3_in;
        in_beat.reg_write  = reg_write_in && cond_ok;
        in_beat.mem_write  = mem_write_in && cond_ok;
        in_beat.mem_to_reg = mem_to_reg_in;
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign retire   = main_valid && out_ready;

    // Main is refilled whenever it is empty or retiring: skid has priority
    // (it is older), otherwise a newly accepted beat goes straight in. When
    // main is stalled, an accepted beat parks in skid. skid_valid implies
    // in_ready=0, so the skid-to-main move never coincides with an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || retire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= in_beat;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid      = main_valid;
    assign alu_result_out = main_q.alu_result;
    assign write_data_out = main_q.write_data;
    assign wa3_out        = main_q.wa3;
    assign reg_write_out  = main_valid && main_q.reg_write;
    assign mem_write_out  = main_valid && main_q.mem_write;
    assign mem_to_reg_out = main_valid && main_q.mem_to_reg;
    assign occupancy      = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_exe_mem.sv
// ---------------------------------------------------------------------------
// tb_pipe_exe_mem
// Self-checking bench for pipe_exe_mem: directed scenarios plus randomized
// traffic compared against a FIFO-queue reference model.
// ---------------------------------------------------------------------------
module tb_pipe_exe_mem;

`ifdef PIPE_EXE_MEM_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result_in = '0;
    logic [31:0] write_data_in = '0;
    logic [3:0]  wa3_in = '0;
    logic        reg_write_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        mem_to_reg_in = 1'b0;
    logic [3:0]  cond_in = 4'b1110;
    logic [3:0]  flags_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_result_out;
    logic [31:0] write_data_out;
    logic [3:0]  wa3_out;
    logic        reg_write_out;
    logic        mem_write_out;
    logic        mem_to_reg_out;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa3;
        logic        rw;
        logic        mw;
        logic        mtr;
    } model_beat_t;

    model_beat_t fifo[$];

    pipe_exe_mem dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result_in  (alu_result_in),
        .write_data_in  (write_data_in),
        .wa3_in         (wa3_in),
        .reg_write_in   (reg_write_in),
        .mem_write_in   (mem_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .cond_in        (cond_in),
        .flags_in       (flags_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_result_out (alu_result_out),
        .write_data_out (write_data_out),
        .wa3_out        (wa3_out),
        .reg_write_out  (reg_write_out),
        .mem_write_out  (mem_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Truth table of all sixteen condition codes, indexed by cond.
    function automatic bit model_cond(input logic [3:0] cond, input logic [3:0] flags);
        bit n, z, c, v;
        bit [15:0] truth;
        n = flags[3]; z = flags[2]; c = flags[1]; v = flags[0];
        truth = {1'b1, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v),
                 !c | z, c & !z, !v, v, !n, n, !c, c, !z, z};
        return truth[cond];
    endfunction

    task automatic set_idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_result_in = '0; write_data_in = '0; wa3_in = '0;
        reg_write_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
        cond_in = 4'b1110; flags_in = '0;
    endtask

    task automatic offer(input logic [31:0] alu);
        in_valid = 1'b1; alu_result_in = alu; write_data_in = ~alu;
        wa3_in = alu[3:0]; reg_write_in = 1'b1; mem_write_in = 1'b0;
        mem_to_reg_in = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fifo.delete();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if ({alu_result_out, write_data_out, wa3_out, reg_write_out, mem_write_out, mem_to_reg_out} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h/%h/%h/%b%b%b want all 0", alu_result_out, write_data_out, wa3_out, reg_write_out, mem_write_out, mem_to_reg_out);
        end
        do_reset();
    endtask

    task automatic test_single();
        offer(32'h10); out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        checks++; if (alu_result_out !== 32'h10) begin errors++; $display("FAIL single_alu got %h want 00000010", alu_result_out); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occupancy got %0d want 1", occupancy); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", out_valid); end
        do_reset();
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        offer(32'd1); @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_after_a got %b want 1", in_ready); end
        offer(32'd2); @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_after_b got %b want 0", in_ready); end
        offer(32'd3); @(posedge clk); #1;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_occupancy got %0d want 2", occupancy); end
        checks++; if (alu_result_out !== 32'd1) begin errors++; $display("FAIL skid_main_a got %h want 1", alu_result_out); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (alu_result_out !== 32'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_out_b got %h/%b want 2/1", alu_result_out, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_rise got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (alu_result_out !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_out_c got %h/%b want 3/1", alu_result_out, out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_no_dup got %b want 0", out_valid); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(i);
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || alu_result_out !== 32'(i)) begin
                errors++; $display("FAIL b2b_beat%0d got %h/%b want %h/1", i, alu_result_out, out_valid, i);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", out_valid); end
        do_reset();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'hA1); @(posedge clk); #1;
        offer(32'hA2); @(posedge clk); #1;
        offer(32'h99); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occupancy got %0d want 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        checks++; if (reg_write_out !== 1'b0 || mem_to_reg_out !== 1'b0) begin errors++; $display("FAIL flush_ctrl got %b%b want 00", reg_write_out, mem_to_reg_out); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %b want 0", out_valid); end
        do_reset();
    endtask

    task automatic test_cond();
        out_ready = 1'b1;
        offer(32'h20); cond_in = 4'b0000; flags_in = 4'b0000;
        @(posedge clk); #1;
        offer(32'h21); flags_in = 4'b0100;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cond_fail_valid got %b want 1", out_valid); end
        checks++; if (reg_write_out !== !COND_EN) begin errors++; $display("FAIL cond_fail_rw got %b want %b", reg_write_out, !COND_EN); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (reg_write_out !== 1'b1 || alu_result_out !== 32'h21) begin errors++; $display("FAIL cond_pass_rw got %b/%h want 1/21", reg_write_out, alu_result_out); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(32'hB1); @(posedge clk); #1;
        offer(32'hB2); @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstmid_full got %0d want 2", occupancy); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_async got v=%b occ=%0d rdy=%b want 0/0/1", out_valid, occupancy, in_ready);
        end
        checks++; if ({alu_result_out, write_data_out, wa3_out, reg_write_out, mem_write_out, mem_to_reg_out} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got %h/%h want 0", alu_result_out, write_data_out);
        end
        #1 rst = 1'b0;
        offer(32'h55); out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_result_out !== 32'h55 || occupancy !== 2'd1) begin
            errors++; $display("FAIL rstmid_first got %b/%h/%0d want 1/55/1", out_valid, alu_result_out, occupancy);
        end
        do_reset();
    endtask

    task automatic test_random_traffic();
        model_beat_t b;
        bit acc, ret;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 31) == 0);
            alu_result_in = $urandom;
            write_data_in = $urandom;
            wa3_in        = 4'($urandom);
            reg_write_in  = 1'($urandom);
            mem_write_in  = 1'($urandom);
            mem_to_reg_in = 1'($urandom);
            cond_in       = 4'($urandom);
            flags_in      = 4'($urandom);
            b.alu = alu_result_in; b.wd = write_data_in; b.wa3 = wa3_in;
            b.rw  = reg_write_in && (!COND_EN || model_cond(cond_in, flags_in));
            b.mw  = mem_write_in && (!COND_EN || model_cond(cond_in, flags_in));
            b.mtr = mem_to_reg_in;
            acc = in_valid && (fifo.size() < 2);
            ret = out_ready && (fifo.size() > 0);
            @(posedge clk); #1;
            if (flush) fifo.delete();
            else begin
                if (ret) void'(fifo.pop_front());
                if (acc) fifo.push_back(b);
            end
            checks++; if (out_valid !== (fifo.size() > 0)) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, out_valid, fifo.size() > 0); end
            checks++; if (in_ready !== (fifo.size() < 2)) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, fifo.size() < 2); end
            checks++; if (occupancy !== 2'(fifo.size())) begin errors++; $display("FAIL rnd_occupancy cyc %0d got %0d want %0d", cyc, occupancy, fifo.size()); end
            if (fifo.size() > 0) begin
                checks++; if ({alu_result_out, write_data_out, wa3_out, reg_write_out, mem_write_out, mem_to_reg_out} !==
                              {fifo[0].alu, fifo[0].wd, fifo[0].wa3, fifo[0].rw, fifo[0].mw, fifo[0].mtr}) begin
                    errors++; $display("FAIL rnd_beat cyc %0d got %h %h %h %b%b%b want %h %h %h %b%b%b", cyc,
                        alu_result_out, write_data_out, wa3_out, reg_write_out, mem_write_out, mem_to_reg_out,
                        fifo[0].alu, fifo[0].wd, fifo[0].wa3, fifo[0].rw, fifo[0].mw, fifo[0].mtr);
                end
            end else begin
                checks++; if ({reg_write_out, mem_write_out, mem_to_reg_out} !== 3'b000) begin
                    errors++; $display("FAIL rnd_idle_ctrl cyc %0d got %b%b%b want 000", cyc, reg_write_out, mem_write_out, mem_to_reg_out);
                end
            end
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_back_to_back();
        test_flush();
        test_cond();
        test_reset_mid();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
